// File: rtl/rv_lsu.sv
// rv_lsu: RV32I load/store unit driving a single-port synchronous data RAM
// and, when the RV_LSU_LED_EN macro is defined, a 3-bit LED register at addr[12] = 1.
// Latency: legal access responds 3 cycles after accept (IDLE->MEM->WAIT->RESP),
//          a faulting access 1 cycle after accept (IDLE->RESP).
// Backpressure: req_ready is high only in IDLE; one request is in flight at a time.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   req_valid/req_ready              request handshake
//   req_we/req_funct3/req_addr/req_wdata  request fields, captured on accept
//   rsp_valid/rsp_rdata/rsp_fault    one-cycle response pulse and its payload
//   mem_en/mem_we/mem_addr/mem_be/mem_wdata/mem_rdata  data RAM port
//   leds                             LED register (tied 0 without RV_LSU_LED_EN)
module rv_lsu #(
  parameter int DMEM_AW = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [2:0]         req_funct3,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_fault,
  output logic               mem_en,
  output logic               mem_we,
  output logic [DMEM_AW-1:0] mem_addr,
  output logic [3:0]         mem_be,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata,
  output logic [2:0]         leds
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_fault;
  logic [31:0] r_rdata;

  logic        w_accept;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_fault_in;
  logic        w_led_sel;
  logic [31:0] w_src;
  logic [31:0] w_shifted;
  logic [31:0] w_load_data;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  // Address bits above the RAM index only matter for the LED region select.
  logic        w_unused;
  assign w_unused = ^r_addr[31:DMEM_AW+2];

  assign w_accept = (r_state == S_IDLE) && req_valid;

`ifdef RV_LSU_LED_EN
  logic [2:0] r_leds;
  assign w_led_sel = r_addr[12];
  assign leds      = r_leds;
  assign w_src     = w_led_sel ? {29'b0, r_leds} : mem_rdata;

  // LED write happens on the MEM->WAIT edge; reset wins so an aborted
  // store never reaches the register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_leds <= 3'b000;
    end else if (r_state == S_MEM && r_we && w_led_sel) begin
      // Store data is lane-replicated, so bits [2:0] hold the stored lane.
      r_leds <= w_wdata[2:0];
    end
  end
`else
  assign w_led_sel = 1'b0;
  assign leds      = 3'b000;
  assign w_src     = mem_rdata;
`endif

  // Legality of the incoming request, evaluated only on the accept cycle.
  always_comb begin
    w_illegal  = 1'b0;
    w_misalign = 1'b0;
    if (req_we) begin
      w_illegal = (req_funct3 > 3'd2);
    end else begin
      w_illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
    end
    if (req_funct3[1:0] == 2'b01) begin
      w_misalign = req_addr[0];
    end else if (req_funct3[1:0] == 2'b10) begin
      w_misalign = |req_addr[1:0];
    end
    w_fault_in = w_illegal || w_misalign;
  end

  // Lane selection and sign/zero extension of the returned word.
  always_comb begin
    w_shifted   = w_src >> {r_addr[1:0], 3'b000};
    w_load_data = 32'h0;
    case (r_funct3)
      3'd0:    w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'd1:    w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'd2:    w_load_data = w_src;
      3'd4:    w_load_data = {24'h0, w_shifted[7:0]};
      3'd5:    w_load_data = {16'h0, w_shifted[15:0]};
      default: w_load_data = 32'h0;
    endcase
  end

  // Byte enables and lane-replicated store data; loads read the full word.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_wdata;
    if (r_we) begin
      case (r_funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << r_addr[1:0];
          w_wdata = {4{r_wdata[7:0]}};
        end
        2'b01: begin
          w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{r_wdata[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = r_wdata;
        end
      endcase
    end
  end

  // FSM: state register and request capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_fault  <= 1'b0;
      r_rdata  <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_fault  <= w_fault_in;
        r_rdata  <= 32'h0;
      end else if (r_state == S_WAIT) begin
        // RAM data is valid in WAIT, one cycle after the MEM enable.
        r_rdata <= r_we ? 32'h0 : w_load_data;
      end
    end
  end

  // FSM: next state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = w_fault_in ? S_RESP : S_MEM;
      S_MEM:   w_next = S_WAIT;
      S_WAIT:  w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM: outputs. The RAM port is driven only during MEM on a RAM-region access.
  always_comb begin
    req_ready = (r_state == S_IDLE);
    rsp_valid = (r_state == S_RESP);
    rsp_fault = (r_state == S_RESP) && r_fault;
    rsp_rdata = (r_state == S_RESP) ? r_rdata : 32'h0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = 4'b0000;
    mem_wdata = 32'h0;
    if (r_state == S_MEM && !w_led_sel) begin
      mem_en    = 1'b1;
      mem_we    = r_we;
      mem_addr  = r_addr[DMEM_AW+1:2];
      mem_be    = w_be;
      mem_wdata = w_wdata;
    end
  end

endmodule

// File: tb/tb_rv_lsu.sv
// tb_rv_lsu: directed bench for rv_lsu with a behavioural synchronous RAM.
// Latency: checks response timing relative to the accept edge.
// Backpressure: holds junk requests valid while busy to check they are ignored.
module tb_rv_lsu;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [2:0]  leds;

  int n_cmp = 0;
  int n_err = 0;

  // Observations captured by do_req.
  int          g_en_cyc;
  int          g_en_cnt;
  int          g_rsp_cyc;
  int          g_rsp_cnt;
  logic        g_rdy0;
  logic        g_we;
  logic [31:0] g_addr;
  logic [3:0]  g_be;
  logic [31:0] g_wdata;
  logic        g_fault;
  logic [31:0] g_rdata;

  logic        tb_clr;
  logic [31:0] ram [0:1023];

  rv_lsu #(.DMEM_AW(10)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .leds(leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
      mem_rdata <= 32'h0;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, keep a junk legal request valid while busy, and
  // observe 6 cycles after the accept edge.
  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    g_rdy0     = req_ready;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_we     = ~we;
    req_funct3 = 3'd2;
    req_addr   = 32'h0000_0040;
    req_wdata  = 32'hDEAD_BEEF;
    g_en_cyc = -1; g_en_cnt = 0; g_rsp_cyc = -1; g_rsp_cnt = 0;
    g_we = 1'bx; g_addr = 'x; g_be = 'x; g_wdata = 'x; g_fault = 1'bx; g_rdata = 'x;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (mem_en) begin
        g_en_cnt++;
        if (g_en_cyc < 0) begin
          g_en_cyc = c; g_we = mem_we; g_addr = {22'h0, mem_addr};
          g_be = mem_be; g_wdata = mem_wdata;
        end
      end
      if (rsp_valid) begin
        g_rsp_cnt++;
        if (g_rsp_cyc < 0) begin
          g_rsp_cyc = c; g_fault = rsp_fault; g_rdata = rsp_rdata;
        end
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic chk_ok(input string tag, input logic [31:0] exp_rdata);
    chk({tag, ".ready"}, {31'h0, g_rdy0}, 32'd1);
    chk({tag, ".rsp_cyc"}, g_rsp_cyc, 32'd3);
    chk({tag, ".rsp_cnt"}, g_rsp_cnt, 32'd1);
    chk({tag, ".fault"}, {31'h0, g_fault}, 32'd0);
    chk({tag, ".rdata"}, g_rdata, exp_rdata);
  endtask

  task automatic chk_ram(input string tag, input logic we, input logic [31:0] addr,
                         input logic [3:0] be);
    chk({tag, ".en_cyc"}, g_en_cyc, 32'd1);
    chk({tag, ".en_cnt"}, g_en_cnt, 32'd1);
    chk({tag, ".we"}, {31'h0, g_we}, {31'h0, we});
    chk({tag, ".addr"}, g_addr, addr);
    chk({tag, ".be"}, {28'h0, g_be}, {28'h0, be});
  endtask

  task automatic chk_fault(input string tag);
    chk({tag, ".rsp_cyc"}, g_rsp_cyc, 32'd1);
    chk({tag, ".rsp_cnt"}, g_rsp_cnt, 32'd1);
    chk({tag, ".fault"}, {31'h0, g_fault}, 32'd1);
    chk({tag, ".rdata"}, g_rdata, 32'h0);
    chk({tag, ".en_cnt"}, g_en_cnt, 32'd0);
  endtask

  initial begin
    int rcnt;
    tb_clr = 1'b1;
    reset = 1'b1;
    // A legal request held valid through reset must not be accepted.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.req_ready", {31'h0, req_ready}, 32'd1);
    chk("rst.rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("rst.rsp_fault", {31'h0, rsp_fault}, 32'd0);
    chk("rst.rsp_rdata", rsp_rdata, 32'h0);
    chk("rst.mem_en", {31'h0, mem_en}, 32'd0);
    chk("rst.mem_we", {31'h0, mem_we}, 32'd0);
    chk("rst.mem_be", {28'h0, mem_be}, 32'h0);
    chk("rst.mem_addr", {22'h0, mem_addr}, 32'h0);
    chk("rst.mem_wdata", mem_wdata, 32'h0);
    chk("rst.leds", {29'h0, leds}, 32'h0);
    reset = 1'b0; req_valid = 1'b0; tb_clr = 1'b0;

    // Word store.
    do_req(1'b1, 3'd2, 32'h10, 32'hCAFE_BABE);
    chk_ram("sw10", 1'b1, 32'd4, 4'b1111);
    chk("sw10.wdata", g_wdata, 32'hCAFE_BABE);
    chk_ok("sw10", 32'h0);
    chk("sw10.ram", ram[4], 32'hCAFE_BABE);

    // Loads with extension from word 4 = 0x8081F0F0.
    do_req(1'b1, 3'd2, 32'h10, 32'h8081_F0F0);
    do_req(1'b0, 3'd2, 32'h10, 32'h0);
    chk_ram("lw10", 1'b0, 32'd4, 4'b1111);
    chk_ok("lw10", 32'h8081_F0F0);
    do_req(1'b0, 3'd0, 32'h13, 32'h0);
    chk_ok("lb13", 32'hFFFF_FF80);
    do_req(1'b0, 3'd4, 32'h13, 32'h0);
    chk_ok("lbu13", 32'h0000_0080);
    do_req(1'b0, 3'd1, 32'h12, 32'h0);
    chk_ok("lh12", 32'hFFFF_8081);
    do_req(1'b0, 3'd5, 32'h10, 32'h0);
    chk_ok("lhu10", 32'h0000_F0F0);

    // Byte and halfword stores: lane enables and replicated data.
    do_req(1'b1, 3'd0, 32'h21, 32'hFFFF_FFA5);
    chk_ram("sb21", 1'b1, 32'd8, 4'b0010);
    chk("sb21.wdata", g_wdata, 32'hA5A5_A5A5);
    chk_ok("sb21", 32'h0);
    do_req(1'b1, 3'd1, 32'h22, 32'hDEAD_1234);
    chk_ram("sh22", 1'b1, 32'd8, 4'b1100);
    chk("sh22.wdata", g_wdata, 32'h1234_1234);
    do_req(1'b0, 3'd2, 32'h20, 32'h0);
    chk_ok("lw20", 32'h1234_A500);

    // Faults: misaligned and illegal.
    do_req(1'b0, 3'd2, 32'h6, 32'h0);
    chk_fault("lw6");
    do_req(1'b1, 3'd4, 32'h30, 32'h1111_1111);
    chk_fault("st_f4");
    do_req(1'b0, 3'd1, 32'h11, 32'h0);
    chk_fault("lh11");
    do_req(1'b0, 3'd3, 32'h0, 32'h0);
    chk_fault("ld_f3");
    do_req(1'b0, 3'd2, 32'h30, 32'h0);
    chk_ok("lw30_untouched", 32'h0);

    // Address bits above the RAM index wrap onto the same word.
    do_req(1'b1, 3'd2, 32'h2010, 32'h1122_3344);
    chk_ram("sw2010", 1'b1, 32'd4, 4'b1111);
    do_req(1'b0, 3'd2, 32'h10, 32'h0);
    chk_ok("lw10_wrap", 32'h1122_3344);

`ifdef RV_LSU_LED_EN
    do_req(1'b1, 3'd2, 32'h1000, 32'h5);
    chk("led_sw.en_cnt", g_en_cnt, 32'd0);
    chk_ok("led_sw", 32'h0);
    chk("led_sw.leds", {29'h0, leds}, 32'h5);
    do_req(1'b0, 3'd2, 32'h1000, 32'h0);
    chk("led_lw.en_cnt", g_en_cnt, 32'd0);
    chk_ok("led_lw", 32'h5);
`else
    do_req(1'b1, 3'd2, 32'h1000, 32'h5);
    chk_ram("noled_sw", 1'b1, 32'd0, 4'b1111);
    chk("noled_sw.leds", {29'h0, leds}, 32'h0);
    do_req(1'b0, 3'd2, 32'h0, 32'h0);
    chk_ok("noled_lw0", 32'h5);
`endif

    // Reset during the MEM cycle of a store aborts it; a valid request
    // held through the reset edge must not be accepted.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h1000; req_wdata = 32'h7;
    @(posedge clk);
    #1;
    req_we = 1'b0; req_addr = 32'h20;
    @(negedge clk);
    chk("rstmid.busy", {31'h0, req_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid.ready", {31'h0, req_ready}, 32'd1);
    chk("rstmid.rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("rstmid.leds", {29'h0, leds}, 32'h0);
    reset = 1'b0; req_valid = 1'b0;
    rcnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) rcnt++;
    end
    chk("rstmid.no_rsp", rcnt, 32'd0);
    chk("rstmid.leds_after", {29'h0, leds}, 32'h0);

    do_req(1'b0, 3'd2, 32'h20, 32'h0);
    chk_ok("lw20_after_rst", 32'h1234_A500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at 1 ms, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
